// File: rtl/store_rmw_ctrl_pkg.sv
// Shared types for the store read-modify-write sequencer: store sizes, FSM states
// and the natural-alignment rule.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_D = 2'b00,
        SZ_W = 2'b01,
        SZ_H = 2'b10,
        SZ_B = 2'b11
    } store_size_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } rmw_state_t;

    // A store is legal when its address is naturally aligned to its size.
    function automatic logic is_aligned(input store_size_t size, input logic [2:0] lo);
        logic ok;
        unique case (size)
            SZ_D:    ok = (lo == 3'b000);
            SZ_W:    ok = (lo[1:0] == 2'b00);
            SZ_H:    ok = (lo[0] == 1'b0);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/store_rmw_ctrl_if.sv
// Bundle between the control unit (request side) and the data memory (mem side)
// as seen by the store sequencer.
interface store_rmw_ctrl_if;
    // Request is taken on a cycle with req_valid & req_ready; the requester keeps
    // req_valid and its payload stable until then. done pulses once per accepted request.
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_size;
    logic        done;
    logic        err;
    logic [63:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata,
        output req_ready, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata,
        input  req_ready, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/store_rmw_ctrl_lane_merge.sv
// Replaces the sized byte lane at a byte offset of a 64-bit word with the low bytes
// of the store data; all other bytes pass through unchanged.
module store_lane_merge
    import store_pkg::*;
(
    input  logic [63:0] rdata_i,
    input  logic [63:0] data_i,
    input  store_size_t size_i,
    input  logic [2:0]  off_i,
    output logic [63:0] merged_o
);

    logic [63:0] lane_mask;
    logic [63:0] mask;
    logic [63:0] shifted;

    always_comb begin
        unique case (size_i)
            SZ_W:    lane_mask = 64'h0000_0000_FFFF_FFFF;
            SZ_H:    lane_mask = 64'h0000_0000_0000_FFFF;
            SZ_B:    lane_mask = 64'h0000_0000_0000_00FF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        mask     = lane_mask << {off_i, 3'b000};
        shifted  = data_i << {off_i, 3'b000};
        merged_o = (rdata_i & ~mask) | (shifted & mask);
    end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Store sequencer for a word-wide memory without byte enables: sd writes directly,
// sw/sh/sb read the word, merge the lane and write it back.
module store_rmw_ctrl
    import store_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    store_rmw_ctrl_if.slave  bus,
    output rmw_state_t       dbg_state_o
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    rmw_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [63:0] addr_q, data_q, merge_q, merged;
    store_size_t size_q;
    logic        err_q;
    logic        accept;
    logic        req_ok;
    logic [63:0] word_addr;

    assign accept      = (state_q == IDLE) && bus.req_valid;
    assign req_ok      = is_aligned(store_size_t'(bus.req_size), bus.req_addr[2:0]);
    assign word_addr   = {addr_q[63:3], 3'b000};
    assign dbg_state_o = state_q;

    store_lane_merge u_merge (
        .rdata_i  (bus.mem_rdata),
        .data_i   (data_q),
        .size_i   (size_q),
        .off_i    (addr_q[2:0]),
        .merged_o (merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!req_ok)                                     state_d = DONE;
                    else if (store_size_t'(bus.req_size) == SZ_D)    state_d = WRITE;
                    else                                             state_d = READ;
                end
            end
            READ:    state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = WRITE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The counter is reloaded in READ so the last WAIT cycle lines up with rdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= SZ_D;
            err_q   <= 1'b0;
            merge_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= bus.req_addr;
                data_q <= bus.req_data;
                size_q <= store_size_t'(bus.req_size);
                err_q  <= !req_ok;
            end
            if (state_q == READ)
                cnt_q <= CW'(MEM_LAT - 1);
            else if (state_q == WAIT && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
            if (state_q == WAIT && cnt_q == '0)
                merge_q <= merged;
        end
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (state_q)
            READ: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = word_addr;
            end
            WAIT: bus.mem_addr = word_addr;
            WRITE: begin
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = word_addr;
                bus.mem_wdata = (size_q == SZ_D) ? data_q : merge_q;
            end
            DONE: begin
                bus.done = 1'b1;
                bus.err  = err_q;
            end
            default: ;
        endcase
    end

endmodule
